mem_arbiter: RTL and testbench

- Sequences a single-port unified instruction/data memory between the IF stage fetch port and the MEM stage data port.
- Grants one access at a time, tracks fixed memory latency and returns data with a ready pulse to the owner.
- Drives a fetch stall so the IF stage holds its PC while a fetch is outstanding.
- Sits between the pipeline stages and the memory model, replacing direct Imem/Dmem wiring.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory command signals of the unified-memory arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ready;
    logic [31:0] if_data;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        mem_cmd_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_data, if_stall, dm_ready, dm_rdata,
               mem_cmd_valid, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_data, if_stall, dm_ready, dm_rdata,
               mem_cmd_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between the IF fetch and MEM data requesters
module mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, squash_q, squash_d;
    logic mem_cmd_valid_q, mem_cmd_valid_d, mem_we_q, mem_we_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic done, decide, if_elig, dm_elig, grant_if, grant_dm, if_ready, dm_ready;
    always_comb begin
        done     = state_q == WAIT && lat_cnt_q == '0;
        decide   = state_q == IDLE || done;
        if_elig  = bus.if_req && !(done && !owner_q);
        dm_elig  = bus.dm_req && !(done && owner_q);
        // DM has priority until the starvation count saturates, then IF takes the slot
        grant_dm = decide && dm_elig && (!if_elig || starve_cnt_q != SW'(STARVE_LIMIT));
        grant_if = decide && if_elig && !grant_dm;
        if_ready = done && !owner_q && !squash_q && !bus.if_flush;
        dm_ready = done && owner_q;
    end
    always_comb begin
        state_d         = done ? IDLE : state_q;
        owner_d         = owner_q;
        lat_cnt_d       = state_q == WAIT && !done ? lat_cnt_q - LW'(1) : lat_cnt_q;
        squash_d        = squash_q || (state_q == WAIT && !owner_q && bus.if_flush);
        starve_cnt_d    = starve_cnt_q;
        mem_cmd_valid_d = 1'b0;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        if (grant_if || grant_dm) begin
            state_d         = WAIT;
            owner_d         = grant_dm;
            lat_cnt_d       = LW'(MEM_LATENCY);
            squash_d        = 1'b0;
            mem_cmd_valid_d = 1'b1;
            mem_we_d        = grant_dm && bus.dm_we;
            mem_addr_d      = grant_dm ? {bus.dm_addr[31:2], 2'b00} : {bus.if_addr[31:2], 2'b00};
            mem_wdata_d     = grant_dm ? bus.dm_wdata : '0;
            starve_cnt_d    = grant_if ? '0 :
                              (bus.if_req && starve_cnt_q != SW'(STARVE_LIMIT)) ? starve_cnt_q + SW'(1) :
                              starve_cnt_q;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            squash_q        <= 1'b0;
            lat_cnt_q       <= '0;
            starve_cnt_q    <= '0;
            mem_cmd_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            squash_q        <= squash_d;
            lat_cnt_q       <= lat_cnt_d;
            starve_cnt_q    <= starve_cnt_d;
            mem_cmd_valid_q <= mem_cmd_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end
    assign bus.if_ready      = if_ready;
    assign bus.if_data       = if_ready ? bus.mem_rdata : '0;
    assign bus.if_stall      = bus.if_req && !if_ready;
    assign bus.dm_ready      = dm_ready;
    assign bus.dm_rdata      = dm_ready && !mem_we_q ? bus.mem_rdata : '0;
    assign bus.mem_cmd_valid = mem_cmd_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, async reset sequence and randomized run against a cycle-stamp model
module tb_mem_arbiter;
    localparam int L  = 2;
    localparam int SL = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // ctl = {if_req, if_flush, dm_req, dm_we}; eb = {if_ready, if_stall, dm_ready, mem_cmd_valid, mem_we}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] ia, da, dd, rd;
        logic [4:0]  eb;
        logic [31:0] e_id, e_dd, e_ma, e_wd;
    } vec_t;
    vec_t vt[$];
    task automatic drive_idle();
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0;
    endtask
    task automatic chk_all_zero(input string tag);
        chk1({tag, " if_ready"}, bus.if_ready, 1'b0);
        chk1({tag, " dm_ready"}, bus.dm_ready, 1'b0);
        chk32({tag, " if_data"}, bus.if_data, 32'h0);
        chk32({tag, " dm_rdata"}, bus.dm_rdata, 32'h0);
        chk1({tag, " mem_cmd_valid"}, bus.mem_cmd_valid, 1'b0);
        chk1({tag, " mem_we"}, bus.mem_we, 1'b0);
        chk32({tag, " mem_addr"}, bus.mem_addr, 32'h0);
        chk32({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
    endtask
    // reference model state: absolute cycle stamps of strobe and completion
    bit m_busy, m_owner, m_squash, m_we;
    int m_strobe, m_done, m_starve;
    logic [31:0] m_addr, m_wdata;
    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_squash = 0; m_we = 0;
        m_strobe = -1; m_done = -1; m_starve = 0; m_addr = '0; m_wdata = '0;
    endtask
    initial begin
        drive_idle();
        #2;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        vt.push_back('{4'b1000, 32'h40, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h0, 32'h0});
        vt.push_back('{4'b1000, 32'h40, 32'h0, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h40, 32'h0});
        vt.push_back('{4'b1000, 32'h40, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h40, 32'h0});
        vt.push_back('{4'b1000, 32'h40, 32'h0, 32'h0, 32'h11111111, 5'b10000, 32'h11111111, 32'h0, 32'h40, 32'h0});
        vt.push_back('{4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h40, 32'h0});
        vt.push_back('{4'b1010, 32'h44, 32'h100, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h40, 32'h0});
        vt.push_back('{4'b1010, 32'h44, 32'h100, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h100, 32'h0});
        vt.push_back('{4'b1010, 32'h44, 32'h100, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h100, 32'h0});
        vt.push_back('{4'b1010, 32'h44, 32'h100, 32'h0, 32'h22222222, 5'b01100, 32'h0, 32'h22222222, 32'h100, 32'h0});
        vt.push_back('{4'b1000, 32'h44, 32'h0, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h44, 32'h0});
        vt.push_back('{4'b1000, 32'h44, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h44, 32'h0});
        vt.push_back('{4'b1000, 32'h44, 32'h0, 32'h0, 32'h33333333, 5'b10000, 32'h33333333, 32'h0, 32'h44, 32'h0});
        vt.push_back('{4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h44, 32'h0});
        vt.push_back('{4'b1000, 32'h48, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h44, 32'h0});
        vt.push_back('{4'b1000, 32'h48, 32'h0, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h48, 32'h0});
        vt.push_back('{4'b1000, 32'h48, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h48, 32'h0});
        vt.push_back('{4'b1010, 32'h48, 32'h104, 32'h0, 32'h44444444, 5'b10000, 32'h44444444, 32'h0, 32'h48, 32'h0});
        vt.push_back('{4'b0010, 32'h0, 32'h104, 32'h0, 32'h0, 5'b00010, 32'h0, 32'h0, 32'h104, 32'h0});
        vt.push_back('{4'b0010, 32'h0, 32'h104, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h104, 32'h0});
        vt.push_back('{4'b0010, 32'h0, 32'h104, 32'h0, 32'h55555555, 5'b00100, 32'h0, 32'h55555555, 32'h104, 32'h0});
        vt.push_back('{4'b1010, 32'h4C, 32'h108, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h104, 32'h0});
        vt.push_back('{4'b1010, 32'h4C, 32'h108, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h4C, 32'h0});
        vt.push_back('{4'b1010, 32'h4C, 32'h108, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h4C, 32'h0});
        vt.push_back('{4'b1010, 32'h4C, 32'h108, 32'h0, 32'h66666666, 5'b10000, 32'h66666666, 32'h0, 32'h4C, 32'h0});
        vt.push_back('{4'b0010, 32'h0, 32'h108, 32'h0, 32'h0, 5'b00010, 32'h0, 32'h0, 32'h108, 32'h0});
        vt.push_back('{4'b0010, 32'h0, 32'h108, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h108, 32'h0});
        vt.push_back('{4'b0010, 32'h0, 32'h108, 32'h0, 32'h77777777, 5'b00100, 32'h0, 32'h77777777, 32'h108, 32'h0});
        vt.push_back('{4'b0011, 32'h0, 32'h203, 32'hDEADBEEF, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h108, 32'h0});
        vt.push_back('{4'b0011, 32'h0, 32'h203, 32'hDEADBEEF, 32'h0, 5'b00011, 32'h0, 32'h0, 32'h200, 32'hDEADBEEF});
        vt.push_back('{4'b0011, 32'h0, 32'h203, 32'hDEADBEEF, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h200, 32'hDEADBEEF});
        vt.push_back('{4'b0011, 32'h0, 32'h203, 32'hDEADBEEF, 32'h88888888, 5'b00101, 32'h0, 32'h0, 32'h200, 32'hDEADBEEF});
        vt.push_back('{4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00001, 32'h0, 32'h0, 32'h200, 32'hDEADBEEF});
        vt.push_back('{4'b1000, 32'h60, 32'h0, 32'h0, 32'h0, 5'b01001, 32'h0, 32'h0, 32'h200, 32'hDEADBEEF});
        vt.push_back('{4'b1000, 32'h60, 32'h0, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h60, 32'h0});
        vt.push_back('{4'b1100, 32'h60, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h60, 32'h0});
        vt.push_back('{4'b1000, 32'h80, 32'h0, 32'h0, 32'h99999999, 5'b01000, 32'h0, 32'h0, 32'h60, 32'h0});
        vt.push_back('{4'b1000, 32'h80, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h60, 32'h0});
        vt.push_back('{4'b1000, 32'h80, 32'h0, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h80, 32'h0});
        vt.push_back('{4'b1000, 32'h80, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h80, 32'h0});
        vt.push_back('{4'b1000, 32'h80, 32'h0, 32'h0, 32'hAAAAAAAA, 5'b10000, 32'hAAAAAAAA, 32'h0, 32'h80, 32'h0});
        vt.push_back('{4'b1000, 32'h90, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h80, 32'h0});
        vt.push_back('{4'b1000, 32'h90, 32'h0, 32'h0, 32'h0, 5'b01010, 32'h0, 32'h0, 32'h90, 32'h0});
        vt.push_back('{4'b1000, 32'h90, 32'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 32'h0, 32'h90, 32'h0});
        vt.push_back('{4'b1100, 32'h90, 32'h0, 32'h0, 32'hBBBBBBBB, 5'b01000, 32'h0, 32'h0, 32'h90, 32'h0});
        vt.push_back('{4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0, 32'h90, 32'h0});
        foreach (vt[i]) begin
            @(posedge clk); #1;
            {bus.if_req, bus.if_flush, bus.dm_req, bus.dm_we} = vt[i].ctl;
            bus.if_addr = vt[i].ia; bus.dm_addr = vt[i].da; bus.dm_wdata = vt[i].dd; bus.mem_rdata = vt[i].rd;
            @(negedge clk);
            chk1($sformatf("v%0d if_ready", i), bus.if_ready, vt[i].eb[4]);
            chk1($sformatf("v%0d if_stall", i), bus.if_stall, vt[i].eb[3]);
            chk1($sformatf("v%0d dm_ready", i), bus.dm_ready, vt[i].eb[2]);
            chk1($sformatf("v%0d mem_cmd_valid", i), bus.mem_cmd_valid, vt[i].eb[1]);
            chk1($sformatf("v%0d mem_we", i), bus.mem_we, vt[i].eb[0]);
            chk32($sformatf("v%0d if_data", i), bus.if_data, vt[i].e_id);
            chk32($sformatf("v%0d dm_rdata", i), bus.dm_rdata, vt[i].e_dd);
            chk32($sformatf("v%0d mem_addr", i), bus.mem_addr, vt[i].e_ma);
            chk32($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vt[i].e_wd);
        end
        // asynchronous reset during the strobe cycle of a fetch
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'hC0;
        @(posedge clk); @(negedge clk);
        chk1("pre-rst strobe", bus.mem_cmd_valid, 1'b1);
        chk32("pre-rst mem_addr", bus.mem_addr, 32'hC0);
        #2 rst = 1'b1;
        #1 chk_all_zero("async rst");
        @(posedge clk); #1;
        bus.if_req = 1'b0; rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1 bus.mem_rdata = $urandom;
            @(negedge clk);
            chk1($sformatf("abandoned %0d if_ready", k), bus.if_ready, 1'b0);
            chk1($sformatf("abandoned %0d strobe", k), bus.mem_cmd_valid, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.if_req = k < 4; bus.if_addr = 32'hC4; bus.mem_rdata = 32'h1000 + k;
            @(negedge clk);
            chk1($sformatf("post-rst %0d strobe", k), bus.mem_cmd_valid, k == 1);
            chk1($sformatf("post-rst %0d if_ready", k), bus.if_ready, k == 3);
            chk32($sformatf("post-rst %0d if_data", k), bus.if_data, k == 3 ? 32'h1003 : 32'h0);
        end
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        // randomized traffic from protocol-abiding requesters
        begin
            bit last_ifr, last_dmr, done, e_ifr, e_dmr, decide, ie, de, pick_dm;
            last_ifr = 0; last_dmr = 0;
            for (int n = 0; n < 1500; n++) begin
                @(posedge clk); #1;
                if (bus.if_req ? last_ifr : ($urandom_range(2) == 0)) begin
                    bus.if_req = bus.if_req ? ($urandom_range(1) == 1) : 1'b1;
                    bus.if_addr = $urandom;
                end
                bus.if_flush = bus.if_req && $urandom_range(7) == 0;
                if (bus.if_flush) bus.if_addr = $urandom;
                if (bus.dm_req ? last_dmr : ($urandom_range(2) == 0)) begin
                    bus.dm_req = bus.dm_req ? ($urandom_range(1) == 1) : 1'b1;
                    bus.dm_we = $urandom_range(1) == 1;
                    bus.dm_addr = $urandom;
                    bus.dm_wdata = $urandom;
                end
                bus.mem_rdata = $urandom;
                @(negedge clk);
                done = m_busy && n == m_done;
                e_ifr = done && !m_owner && !m_squash && !bus.if_flush;
                e_dmr = done && m_owner;
                chk1($sformatf("rnd%0d if_ready", n), bus.if_ready, e_ifr);
                chk1($sformatf("rnd%0d dm_ready", n), bus.dm_ready, e_dmr);
                chk1($sformatf("rnd%0d if_stall", n), bus.if_stall, bus.if_req && !e_ifr);
                chk32($sformatf("rnd%0d if_data", n), bus.if_data, e_ifr ? bus.mem_rdata : 32'h0);
                chk32($sformatf("rnd%0d dm_rdata", n), bus.dm_rdata, (e_dmr && !m_we) ? bus.mem_rdata : 32'h0);
                chk1($sformatf("rnd%0d strobe", n), bus.mem_cmd_valid, m_busy && n == m_strobe);
                chk1($sformatf("rnd%0d mem_we", n), bus.mem_we, m_we);
                chk32($sformatf("rnd%0d mem_addr", n), bus.mem_addr, m_addr);
                chk32($sformatf("rnd%0d mem_wdata", n), bus.mem_wdata, m_wdata);
                last_ifr = bus.if_ready; last_dmr = bus.dm_ready;
                if (m_busy && !done && !m_owner && bus.if_flush) m_squash = 1;
                decide = !m_busy || done;
                ie = bus.if_req && !(done && !m_owner);
                de = bus.dm_req && !(done && m_owner);
                if (decide && (ie || de)) begin
                    pick_dm = de && (!ie || m_starve < SL);
                    if (pick_dm) begin
                        if (bus.if_req && m_starve < SL) m_starve++;
                    end else m_starve = 0;
                    m_owner = pick_dm; m_busy = 1; m_squash = 0;
                    m_strobe = n + 1; m_done = n + 1 + L;
                    m_we = pick_dm && bus.dm_we;
                    m_addr = (pick_dm ? bus.dm_addr : bus.if_addr) & 32'hFFFF_FFFC;
                    m_wdata = pick_dm ? bus.dm_wdata : 32'h0;
                end else if (done) m_busy = 0;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
